// File: rtl/count_sequencer_if.sv
// Control and status bundle for count_sequencer.
// COUNT_SEQ_DOWN_EN adds the dir (count-down) control.
interface count_sequencer_if;
    logic       start;
    logic       stop;
    logic       sync_clr;
    logic [1:0] rate_sel;
    logic [7:0] limit;
`ifdef COUNT_SEQ_DOWN_EN
    logic       dir;
`endif
    logic [7:0] count;
    logic       tick;
    logic       wrap;
    logic       running;

`ifdef COUNT_SEQ_DOWN_EN
    modport master (output start, stop, sync_clr, rate_sel, limit, dir,
                    input  count, tick, wrap, running);
    modport slave  (input  start, stop, sync_clr, rate_sel, limit, dir,
                    output count, tick, wrap, running);
`else
    modport master (output start, stop, sync_clr, rate_sel, limit,
                    input  count, tick, wrap, running);
    modport slave  (input  start, stop, sync_clr, rate_sel, limit,
                    output count, tick, wrap, running);
`endif
endinterface

// File: rtl/count_sequencer.sv
// Run/pause sequencer and tick-rate divider for the 8-bit display counter.
// COUNT_SEQ_DOWN_EN adds count-down operation selected by bus.dir.
//
// state   | meaning
// S_IDLE  | count and divider held at 0, waiting for start
// S_RUN   | divider running, count updates on each divider terminal count
// S_PAUSE | count and divider frozen, start resumes, stop returns to idle
module count_sequencer #(
    parameter int TICK_BASE = 50_000_000
) (
    input logic              clock,
    input logic              clear_n,
    count_sequencer_if.slave bus
);
    localparam int DIV_W = $clog2(4 * TICK_BASE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t           state, nxt_state;
    logic [DIV_W-1:0] div, nxt_div, reload;
    logic [7:0]       count, nxt_count, stepped;
    logic             tick, nxt_tick;
    logic             wrap, nxt_wrap, step_wrap;
    logic             running;
    logic             down;

`ifdef COUNT_SEQ_DOWN_EN
    assign down = bus.dir;
`else
    assign down = 1'b0;
`endif

    // Period minus one, so the divider reaches 0 exactly once per period.
    always_comb begin
        reload = '0;
        case (bus.rate_sel)
            2'b00:   reload = '0;
            2'b01:   reload = DIV_W'(TICK_BASE - 1);
            2'b10:   reload = DIV_W'(2 * TICK_BASE - 1);
            default: reload = DIV_W'(4 * TICK_BASE - 1);
        endcase
    end

    always_comb begin
        stepped   = count;
        step_wrap = 1'b0;
        if (down) begin
            if (count == 8'd0 || count > bus.limit) begin
                stepped   = bus.limit;
                step_wrap = 1'b1;
            end else begin
                stepped = count - 8'd1;
            end
        end else begin
            if (count >= bus.limit) begin
                stepped   = 8'd0;
                step_wrap = 1'b1;
            end else begin
                stepped = count + 8'd1;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_count = count;
        nxt_div   = div;
        nxt_tick  = 1'b0;
        nxt_wrap  = 1'b0;
        if (bus.sync_clr) begin
            nxt_state = S_IDLE;
            nxt_count = 8'd0;
            nxt_div   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    nxt_count = 8'd0;
                    nxt_div   = '0;
                    if (!bus.stop && bus.start) begin
                        nxt_state = S_RUN;
                        nxt_div   = reload;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        nxt_state = S_PAUSE;
                    end else if (div == '0) begin
                        nxt_tick  = 1'b1;
                        nxt_wrap  = step_wrap;
                        nxt_count = stepped;
                        nxt_div   = reload;
                    end else begin
                        nxt_div = div - DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.stop) begin
                        nxt_state = S_IDLE;
                        nxt_count = 8'd0;
                        nxt_div   = '0;
                    end else if (bus.start) begin
                        nxt_state = S_RUN;
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_count = 8'd0;
                    nxt_div   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= S_IDLE;
            count   <= 8'd0;
            div     <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= nxt_state;
            count   <= nxt_count;
            div     <= nxt_div;
            tick    <= nxt_tick;
            wrap    <= nxt_wrap;
            running <= (nxt_state == S_RUN);
        end
    end

    assign bus.count   = count;
    assign bus.tick    = tick;
    assign bus.wrap    = wrap;
    assign bus.running = running;
endmodule
